// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one partial-product iteration per cycle,
// unsigned or two's-complement operands selected per transaction.
//
// state | meaning
// IDLE  | waiting for operands, in_ready = 1
// RUN   | WIDTH iterations, one multiplier bit per cycle
// DONE  | product held with out_valid = 1 until out_ready
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_flag;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               transfer;
  logic               last_iter;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  // State register; reset wins over any handshake in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (cnt == LAST_CNT) next_state = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand magnitudes and one partial-product step; the sum wraps at 2*WIDTH bits.
  always_comb begin
    transfer  = in_valid && in_ready;
    last_iter = (cnt == LAST_CNT);
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    abs_a     = (signed_mode && op_a[WIDTH-1]) ? (WIDTH'(0) - op_a) : op_a;
    abs_b     = (signed_mode && op_b[WIDTH-1]) ? (WIDTH'(0) - op_b) : op_b;
    addend    = mag_b[cnt] ? ({{WIDTH{1'b0}}, mag_a} << cnt) : '0;
    acc_next  = acc + addend;
  end

  // Datapath: capture on transfer, iterate in RUN, hold the result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a     <= '0;
      mag_b     <= '0;
      neg_flag  <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            neg_flag <= signed_mode && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            // Negating zero yields zero, so a zero operand never produces -0.
            product   <= neg_flag ? ((2*WIDTH)'(0) - acc_next) : acc_next;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: WIDTH=4 functional, stall and reset
// cases, plus a WIDTH=8 instance run back-to-back with in_valid held high.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       in_valid = 1'b0, signed_mode = 1'b0, out_ready = 1'b1;
  logic [3:0] op_a = '0, op_b = '0;
  logic       in_ready, out_valid, busy;
  logic [7:0] product;

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  // WIDTH=8 instance
  logic        in_valid8 = 1'b0, signed_mode8 = 1'b0;
  logic [7:0]  op_a8 = '0, op_b8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] product8;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .op_a(op_a8), .op_b(op_b8), .signed_mode(signed_mode8),
    .out_valid(out_valid8), .out_ready(1'b1), .product(product8), .busy(busy8)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set, wait for the result with out_ready high,
  // check latency, value and single-cycle out_valid pulse.
  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic sm, input logic [7:0] exp);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin step(); w++; end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    op_a = a; op_b = b; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    // Transfer in cycle T, out_valid in cycle T+WIDTH+1: WIDTH edges later.
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_prod"}, 32'(product), 32'(exp));
    step();
    chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb;
    sa = $signed({{8{a[7]}}, a});
    sb = $signed({{8{b[7]}}, b});
    if (s) return 16'(sa * sb);
    return {8'h00, a} * {8'h00, b};
  endfunction

  localparam int N8 = 8;
  logic [7:0] tab_a [N8] = '{8'hFF, 8'h80, 8'h80, 8'h7F, 8'h00, 8'h35, 8'hC3, 8'hFF};
  logic [7:0] tab_b [N8] = '{8'hFF, 8'h80, 8'h80, 8'h81, 8'hFF, 8'h6A, 8'h17, 8'hFF};
  logic       tab_s [N8] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};

  initial begin
    logic [7:0] held;
    logic [15:0] expq [$];
    int cyc, idx, last, got;

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy_after", 32'(busy), 32'd0);

    run4("u15x15", 4'hF, 4'hF, 1'b0, 8'hE1);
    run4("s_m3x5", 4'hD, 4'h5, 1'b1, 8'hF1);
    run4("s_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
    run4("s_0xm1", 4'h0, 4'hF, 1'b1, 8'h00);
    run4("u_15x0", 4'hF, 4'h0, 1'b0, 8'h00);
    run4("s_7xm8", 4'h7, 4'h8, 1'b1, 8'hC8);
    run4("s_m1xm1", 4'hF, 4'hF, 1'b1, 8'h01);
    run4("u_8x8", 4'h8, 4'h8, 1'b0, 8'h40);

    // Stall: out_ready low for 10 cycles while inputs toggle.
    op_a = 4'h6; op_b = 4'h3; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    op_a = 4'hF; op_b = 4'hF; signed_mode = 1'b1;
    begin
      int w;
      w = 0;
      while (!out_valid && w < 20) begin
        step(); w++;
        op_a = ~op_a; op_b = op_b + 4'd3; in_valid = ~in_valid; signed_mode = ~signed_mode;
      end
    end
    chk("stall_prod0", 32'(product), 32'h12);
    held = product;
    for (int i = 0; i < 10; i++) begin
      op_a = op_a + 4'd5; op_b = ~op_b; in_valid = ~in_valid; signed_mode = ~signed_mode;
      step();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_hold", 32'(product), 32'(held));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("stall_release", 32'(out_valid), 32'd0);
    chk("stall_idle", 32'(in_ready), 32'd1);

    // Reset during the second RUN cycle discards the operation.
    op_a = 4'h5; op_b = 4'h5; signed_mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_prod", 32'(product), 32'd0);
    rst = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (out_valid) pulses++;
      end
      chk("mid_rst_no_pulse", 32'(pulses), 32'd0);
    end
    run4("u_7x9", 4'h7, 4'h9, 1'b0, 8'h3F);

    // WIDTH=8 back-to-back with in_valid held high.
    cyc = 0; idx = 0; last = -1; got = 0;
    op_a8 = tab_a[0]; op_b8 = tab_b[0]; signed_mode8 = tab_s[0]; in_valid8 = 1'b1;
    while (got < N8 && cyc < 2000) begin
      if (in_ready8 && idx < N8) begin
        if (last >= 0) chk("w8_spacing", 32'(cyc - last), 32'd10);
        last = cyc;
        expq.push_back(ref8(tab_a[idx], tab_b[idx], tab_s[idx]));
        idx++;
      end
      if (out_valid8) begin
        chk("w8_prod", 32'(product8), 32'(expq.pop_front()));
        got++;
      end
      step();
      cyc++;
      if (idx < N8) begin
        op_a8 = tab_a[idx]; op_b8 = tab_b[idx]; signed_mode8 = tab_s[idx];
      end else begin
        in_valid8 = 1'b0;
      end
    end
    chk("w8_results", 32'(got), 32'(N8));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: operand width in bits; legal range 2..16.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port in_valid, input, 1: operands and mode are presented.
REQ-005 Port in_ready, output, 1: the block accepts operands this cycle.
REQ-006 Port op_a, input, WIDTH: multiplicand.
REQ-007 Port op_b, input, WIDTH: multiplier.
REQ-008 Port signed_mode, input, 1: 1 = two's-complement operands, 0 = unsigned.
REQ-009 Port out_valid, output, 1: product is valid.
REQ-010 Port out_ready, input, 1: the consumer takes the product.
REQ-011 Port product, output, 2*WIDTH: the result, in the same signedness as the captured mode.
REQ-012 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid and in_ready are both 1.
REQ-015 On transfer, the block SHALL capture op_a, op_b and signed_mode, clear the accumulator, load iteration counter 0, and enter RUN.
REQ-016 Signed capture SHALL store |op_a| and |op_b| as WIDTH-bit unsigned magnitudes, with neg_flag = sign(op_a) XOR sign(op_b).
REQ-017 Unsigned capture SHALL store the operands unchanged, with neg_flag = 0.
REQ-018 Each RUN cycle SHALL perform exactly one iteration: if multiplier bit [counter] = 1, add (magnitude_a << counter) to the 2*WIDTH-bit accumulator.
REQ-019 Each RUN cycle SHALL then increment the counter.
REQ-020 Accumulator addition SHALL be modulo 2^(2*WIDTH); no carry out of bit 2*WIDTH-1 SHALL be produced.
REQ-021 After the iteration with counter = WIDTH-1, the FSM SHALL enter DONE.
REQ-022 RUN SHALL last exactly WIDTH cycles; there is no early termination on zero operands.
REQ-023 On entering DONE, product SHALL be the accumulator if neg_flag = 0, else its two's-complement negation (2*WIDTH bits).
REQ-024 Latency: transfer at edge T SHALL give out_valid = 1 from edge T+WIDTH+1.
REQ-025 In DONE, out_valid SHALL be 1 and product SHALL hold stable until out_ready = 1.
REQ-026 When out_valid and out_ready are both 1, the FSM SHALL return to IDLE; out_valid SHALL be 0 the next cycle.
REQ-027 in_ready SHALL NOT assert in DONE; a new operand set is accepted no earlier than one cycle after the output handshake.
REQ-028 Sustained throughput SHALL be one product per WIDTH+2 cycles.
REQ-029 in_valid, op_a, op_b and signed_mode SHALL be ignored outside IDLE; changes during RUN or DONE SHALL NOT affect the result.
REQ-030 Signed edge case: with op_a = op_b = -2^(WIDTH-1), the result SHALL be +2^(2*WIDTH-2), exact in 2*WIDTH bits.
REQ-031 A zero operand SHALL yield product 0 with no negative zero; negation of 0 SHALL be 0.
REQ-032 out_valid SHALL be driven from a register; product SHALL be driven from a register.

Reset
REQ-033 While rst = 1 at a clock edge, the FSM SHALL enter IDLE and out_valid SHALL be 0.
REQ-034 While rst = 1 at a clock edge, product, accumulator, counter and neg_flag SHALL be 0; busy SHALL be 0 and in_ready SHALL be 1 the cycle after rst falls.
REQ-035 Reset asserted in RUN or DONE SHALL discard the operation with no out_valid pulse.
REQ-036 rst SHALL take priority over any simultaneous handshake.

Verification
REQ-037 WIDTH=4, unsigned, op_a=15, op_b=15, out_ready=1 -> out_valid at T+5, product=0xE1 (225), one-cycle pulse.
REQ-038 WIDTH=4, signed, op_a=-3 (0xD), op_b=5 -> product=0xF1 (-15); then op_a=-8, op_b=-8 -> product=0x40 (64).
REQ-039 WIDTH=4, out_ready held 0 for 10 cycles after out_valid, with op_a/op_b/in_valid toggling -> product and out_valid stable, in_ready=0 throughout; accept on out_ready=1.
REQ-040 rst pulsed in the second RUN cycle -> next cycle busy=0, out_valid=0, product=0; the next transaction 7x9 unsigned -> 0x3F (63).
REQ-041 WIDTH=8, back-to-back random unsigned and signed pairs with in_valid held high -> every result matches the reference product; spacing is exactly 10 cycles between transfers.
REQ-042 WIDTH=4, op_a=0, op_b=-1 signed -> product=0x00.
